// File: rtl/output_deskewer.sv
// -----------------------------------------------------------------------------
// output_deskewer
//   Realigns the diagonally skewed column outputs of a MATRIX_SIZE-wide
//   systolic array into whole result rows. The rows are buffered in a small
//   FIFO and handed to a consumer through a valid/ready handshake.
//
//   Parameters
//     MATRIX_SIZE  number of columns and rows per result (2 or more)
//     DATA_SIZE    width of one partial-sum element
//
//   Ports
//     clk        sole clock, rising edge
//     reset      synchronous, active-high
//     in_start   one-cycle pulse: column 0 of row 0 is on sum_in this cycle
//     sum_in     skewed column outputs (element j = column j)
//     out_row    realigned result row, registered FIFO head
//     out_valid  out_row holds a valid row (FIFO not empty)
//     out_ready  consumer accepts out_row
//     busy       FSM is not in IDLE
//     done       one-cycle pulse after the last row of a result is transferred
//     err        (DESKEW_ERR_EN only) sticky flag for an ignored in_start
//
//   Optional feature macro: DESKEW_ERR_EN adds the err output.
// -----------------------------------------------------------------------------
module output_deskewer #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_start,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_row,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
`ifdef DESKEW_ERR_EN
  ,
  output logic                                  err
`endif
);

  localparam int unsigned CNT_W = $clog2(2 * MATRIX_SIZE);
  localparam int unsigned PTR_W = $clog2(MATRIX_SIZE);
  localparam int unsigned OCC_W = $clog2(MATRIX_SIZE + 1);

  // Counter window in which aligned rows are written to the FIFO.
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * MATRIX_SIZE - 2);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MATRIX_SIZE - 1);

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Deskew chains: column j is delayed MATRIX_SIZE-1-j cycles so that every
  // column of row i lines up in cycle T+i+MATRIX_SIZE-1.
  // ---------------------------------------------------------------------------
  row_t aligned;

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned STAGES = MATRIX_SIZE - 1 - j;

    if (STAGES == 0) begin : g_pass
      assign aligned[j] = sum_in[j];
    end else begin : g_chain
      logic [DATA_SIZE-1:0] stage [STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < int'(STAGES); k++) begin
            stage[k] <= '0;
          end
        end else begin
          stage[0] <= sum_in[j];
          for (int k = 1; k < int'(STAGES); k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end

      assign aligned[j] = stage[STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;
  logic             fifo_empty;

  // State and capture counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The counter reads 0 in the start cycle, so the first
  // CAPTURE cycle already counts 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_start && fifo_empty) begin
          state_next = CAPTURE;
          cnt_next   = CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (cnt == CNT_LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row FIFO, depth MATRIX_SIZE. A whole result always fits, so writes never
  // stall; out_valid/out_row are registered copies of the next-cycle head.
  // ---------------------------------------------------------------------------
  row_t             mem [MATRIX_SIZE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             wr_en;
  logic             rd_en;
  row_t             head_next;

  assign fifo_empty = (occ == '0);

  // Pointer/occupancy update and next head selection.
  always_comb begin
    wr_en       = (state == CAPTURE) && (cnt >= CNT_FIRST);
    rd_en       = out_valid && out_ready;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    occ_next    = occ;
    head_next   = '0;

    if (wr_en) begin
      wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
    end

    if (wr_en && !rd_en) begin
      occ_next = occ + OCC_W'(1);
    end else if (!wr_en && rd_en) begin
      occ_next = occ - OCC_W'(1);
    end

    // When the FIFO is empty after this cycle's read, the row being written
    // becomes the head directly (it is not in mem until the clock edge).
    if (occ_next != '0) begin
      if (wr_en && (occ == (rd_en ? OCC_W'(1) : OCC_W'(0)))) begin
        head_next = aligned;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Row storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= aligned;
    end
  end

  // FIFO pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
      out_row   <= head_next;
      busy      <= (state_next != IDLE);
      done      <= done_next;
    end
  end

`ifdef DESKEW_ERR_EN
  // Sticky flag for a start pulse that arrives while it would be ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (in_start && (busy || !fifo_empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_output_deskewer.sv
// -----------------------------------------------------------------------------
// tb_output_deskewer
//   Self-checking bench for output_deskewer. Two instances (MATRIX_SIZE 2 and
//   4) share the reset; one is exercised at a time. A reference model tracks
//   each result as a queue of rows, each row becoming available MATRIX_SIZE+i
//   cycles after its start, and predicts out_valid, out_row, busy, done and
//   (when DESKEW_ERR_EN is defined) err every cycle.
// -----------------------------------------------------------------------------
module tb_output_deskewer;

  localparam int unsigned DW  = 32;
  localparam int          INF = 1 << 30;

  typedef logic [3:0][DW-1:0] row_t;
  typedef struct {
    int   avail;
    row_t row;
  } ent_t;

  logic clk;
  logic reset;
  logic start2, ready2, valid2, busy2, done2;
  logic start4, ready4, valid4, busy4, done4;
  logic [1:0][DW-1:0] sum2, row2;
  logic [3:0][DW-1:0] sum4, row4;
`ifdef DESKEW_ERR_EN
  logic err2, err4;
`endif

  output_deskewer #(.MATRIX_SIZE(2), .DATA_SIZE(DW)) dut2 (
    .clk(clk), .reset(reset), .in_start(start2), .sum_in(sum2),
    .out_row(row2), .out_valid(valid2), .out_ready(ready2),
    .busy(busy2), .done(done2)
`ifdef DESKEW_ERR_EN
    , .err(err2)
`endif
  );

  output_deskewer #(.MATRIX_SIZE(4), .DATA_SIZE(DW)) dut4 (
    .clk(clk), .reset(reset), .in_start(start4), .sum_in(sum4),
    .out_row(row4), .out_valid(valid4), .out_ready(ready4),
    .busy(busy4), .done(done4)
`ifdef DESKEW_ERR_EN
    , .err(err4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  ent_t          q[$];
  logic [DW-1:0] cur_mat  [4][4];
  logic [DW-1:0] next_mat [4][4];
  int            cyc, ts, busy_from, busy_until, done_at, pops, n_cur;
  bit            err_exp, post_reset;
  bit            start_now, ready_now, reset_now;
  int            checks, failures;

  task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d cyc=%0d observed=%0h expected=%0h", tag, n_cur, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    ts         = -100;
    busy_from  = 0;
    busy_until = 0;
    done_at    = -1;
    pops       = 0;
    err_exp    = 1'b0;
    post_reset = 1'b1;
  endtask

  task automatic rand_mat();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        next_mat[i][j] = $urandom();
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance.
  task automatic tick();
    bit            acc, busy_exp, v_exp;
    int            i;
    logic [DW-1:0] d;
    row_t          obs_row, r;
    logic          obs_valid, obs_busy, obs_done;
`ifdef DESKEW_ERR_EN
    logic          obs_err;
`endif
    busy_exp = (cyc >= busy_from) && (cyc < busy_until);
    acc      = start_now && !reset_now && !busy_exp && (q.size() == 0);
    if (acc) begin
      cur_mat = next_mat;
      ts      = cyc;
    end

    // Element (i,j) is presented on column j in cycle ts+i+j; noise otherwise.
    for (int j = 0; j < 4; j++) begin
      i = cyc - ts - j;
      d = (i >= 0 && i < n_cur && j < n_cur) ? cur_mat[i][j] : $urandom();
      sum4[j] = d;
      if (j < 2) sum2[j] = d;
    end
    reset  = reset_now;
    start2 = (n_cur == 2) && start_now;
    start4 = (n_cur == 4) && start_now;
    ready2 = (n_cur == 2) ? ready_now : 1'b1;
    ready4 = (n_cur == 4) ? ready_now : 1'b1;

    obs_row = '0;
    if (n_cur == 2) begin
      obs_row[1:0] = row2;
      obs_valid    = valid2;
      obs_busy     = busy2;
      obs_done     = done2;
`ifdef DESKEW_ERR_EN
      obs_err      = err2;
`endif
    end else begin
      obs_row      = row4;
      obs_valid    = valid4;
      obs_busy     = busy4;
      obs_done     = done4;
`ifdef DESKEW_ERR_EN
      obs_err      = err4;
`endif
    end

    v_exp = (q.size() > 0) && (q[0].avail <= cyc);
    chk("out_valid", obs_valid, v_exp);
    chk("busy", obs_busy, busy_exp);
    chk("done", obs_done, cyc == done_at);
    if (v_exp) chk("out_row", obs_row, q[0].row);
    if (post_reset) chk("reset_row", obs_row, '0);
`ifdef DESKEW_ERR_EN
    chk("err", obs_err, err_exp);
`endif

    post_reset = 1'b0;
    if (reset_now) begin
      clear_model();
    end else begin
      if (start_now && !acc) err_exp = 1'b1;
      if (v_exp && ready_now) begin
        void'(q.pop_front());
        pops++;
        if (pops == n_cur) begin
          done_at    = cyc + 2;
          busy_until = cyc + 2;
        end
      end
      if (acc) begin
        busy_from  = cyc + 1;
        busy_until = INF;
        pops       = 0;
        for (int ri = 0; ri < n_cur; ri++) begin
          r = '0;
          for (int j = 0; j < n_cur; j++) r[j] = cur_mat[ri][j];
          q.push_back('{avail: ts + n_cur + ri, row: r});
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    start_now = 1'b0;
    repeat (k) tick();
  endtask

  task automatic random_phase(input int k);
    repeat (k) begin
      start_now = ($urandom_range(0, 3) == 0);
      if (start_now) rand_mat();
      ready_now = ($urandom_range(0, 3) != 0);
      reset_now = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset_now = 1'b0;
    ready_now = 1'b1;
    idle(20);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_cur     = 2;
    cyc       = 0;
    reset     = 1'b1;
    start2    = 1'b0;
    start4    = 1'b0;
    ready2    = 1'b1;
    ready4    = 1'b1;
    sum2      = '0;
    sum4      = '0;
    start_now = 1'b0;
    ready_now = 1'b1;
    reset_now = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cur_mat[i][j]  = '0;
        next_mat[i][j] = '0;
      end
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    idle(2);

    // Basic realignment: {10,20} then {30,40}, done at T+5
    next_mat[0][0] = 32'd10; next_mat[0][1] = 32'd20;
    next_mat[1][0] = 32'd30; next_mat[1][1] = 32'd40;
    start_now = 1'b1;
    tick();
    idle(5);

    // Back-to-back: new start in the cycle after done
    rand_mat();
    start_now = 1'b1;
    tick();
    idle(7);

    // Backpressure: consumer stalled until T+10
    next_mat[0][0] = 32'd10; next_mat[0][1] = 32'd20;
    next_mat[1][0] = 32'd30; next_mat[1][1] = 32'd40;
    ready_now = 1'b0;
    start_now = 1'b1;
    tick();
    idle(9);
    ready_now = 1'b1;
    idle(6);

    // Ignored start at T+1
    rand_mat();
    start_now = 1'b1;
    tick();
    rand_mat();
    start_now = 1'b1;
    tick();
    idle(8);

    // Reset at T+2, then a fresh result
    rand_mat();
    start_now = 1'b1;
    tick();
    idle(1);
    reset_now = 1'b1;
    tick();
    reset_now = 1'b0;
    idle(2);
    rand_mat();
    start_now = 1'b1;
    tick();
    idle(7);

    random_phase(300);

    // Switch to the 4x4 instance
    reset_now = 1'b1;
    tick();
    reset_now = 1'b0;
    n_cur = 4;
    idle(2);

    // Element (i,j) = 16*i+j, first row at T+4
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        next_mat[i][j] = DW'(16 * i + j);
    start_now = 1'b1;
    tick();
    idle(12);

    // Stalled 4x4 result must be fully buffered
    rand_mat();
    ready_now = 1'b0;
    start_now = 1'b1;
    tick();
    idle(14);
    ready_now = 1'b1;
    idle(10);

    random_phase(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
